lif_layer_sequencer: RTL
========================

# lif_layer_sequencer

Time-multiplexes one shared combinational LIF datapath (`lif_logic`) across `NEURONS` neurons of a layer. It stores per-neuron weight vectors and membrane potentials and accepts one input spike vector per timestep. For each neuron in turn it presents that neuron's operands to the datapath, writes back the updated membrane and collects the spikes into one output vector. It sits between the layer's input/output streams and a single `lif_logic` instance, replacing `NEURONS` parallel `neuron_lif` copies.

## Interface
- `SYNAPSES`, 8: inputs per neuron (power of two).
- `NEURONS`, 4: neurons sharing the datapath (≥2).
- `MEMBRANE_BITS`, $clog2(SYNAPSES)+2: signed membrane width.
- `THRESHOLD_BITS`, MEMBRANE_BITS-1: unsigned threshold width.

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_we`  in  1  write `cfg_weights` into the weight slot at `cfg_addr`.
- `cfg_addr`  in  $clog2(NEURONS)  neuron index for a weight write.
- `cfg_weights`  in  SYNAPSES  weight vector.
- `clear_state`  in  1  zero all membranes.
- `shift`  in  3  decay shift, sampled at step accept.
- `threshold`  in  THRESHOLD_BITS  sampled at step accept.
- `in_valid`  in  1  an input vector is offered.
- `in_ready`  out  1  sequencer can accept an input vector.
- `in_spikes`  in  SYNAPSES  input spike vector for the timestep.
- `out_valid`  out  1  the spike vector for a step is available.
- `out_ready`  in  1  consumer takes the result.
- `out_spikes`  out  NEURONS  bit n is the spike of neuron n.
- `busy`  out  1  state ≠ IDLE.
- `dp_inputs`  out  SYNAPSES  to datapath `inputs`.
- `dp_weights`  out  SYNAPSES  to datapath `weights`.
- `dp_last_membrane`  out  MEMBRANE_BITS  to datapath `last_membrane`.
- `dp_shift`  out  3  to datapath `shift`.
- `dp_threshold`  out  THRESHOLD_BITS  to datapath `threshold`.
- `dp_new_membrane`  in  MEMBRANE_BITS  from datapath `new_membrane`.
- `dp_is_spike`  in  1  from datapath `is_spike`.
- `mem_rd_addr`  in  $clog2(NEURONS)  debug read index.
- `mem_rd_data`  out  MEMBRANE_BITS  combinational read of `membrane[mem_rd_addr]`.

## Operation

**FSM states:** IDLE, RUN, DONE.

**IDLE**
- `in_ready`=1.
- On `in_valid`&`in_ready`:
  - latch `in_spikes`, `shift` and `threshold`;
  - set `idx`=0 and clear `spike_acc`;
  - go to RUN.

**RUN**
- Datapath drive, combinational from registers:
  - `dp_inputs` = latched vector;
  - `dp_weights` = `weights[idx]`;
  - `dp_last_membrane` = `membrane[idx]`;
  - `dp_shift` and `dp_threshold` = latched values.
- Each clock edge:
  - `membrane[idx]` ← `dp_new_membrane`, stored unmodified; saturation and reset are the datapath's job;
  - `spike_acc[idx]` ← `dp_is_spike`;
  - `idx`++.
- After the edge with `idx`=NEURONS-1, go to DONE.

**DONE**
- `out_valid`=1 and `out_spikes`=`spike_acc`, both held stable.
- On `out_ready`, go to IDLE.
- `in_ready`=0 until IDLE is reached, so there is no overlap between steps.

**Outside RUN:** the `dp_*` outputs still reflect `idx` and the latched values; the datapath results are ignored.

**Configuration and clear**
- `cfg_we` is honoured only in IDLE. When not in IDLE it is dropped silently.
- `clear_state` is honoured only in IDLE; it zeros every membrane on that edge.
- `clear_state` takes priority over a simultaneous step accept: the clear happens and the accept is deferred. `in_ready`=0 in that cycle.
- `cfg_we` and a step accept in the same IDLE cycle are both performed; the step uses the newly written weights from the RUN cycles onward.

**Reset (async, any state, including mid-RUN)**
- State = IDLE, `idx`=0.
- All membranes = 0, all weights = 0, `spike_acc`=0, latched registers = 0.
- `out_valid`=0, `out_spikes`=0, `busy`=0, `in_ready`=1.
- Membranes of a partially processed step are discarded.

## Timing
- Accept edge is E0. RUN covers edges E1..E_NEURONS; neuron n is written at edge E(n+1).
- `out_valid` rises after edge E_NEURONS, i.e. latency NEURONS cycles from accept to result.
- Minimum step period is NEURONS+2 cycles with `out_ready` held high.
- `out_spikes` and `out_valid` are registered. `in_ready`, `busy` and `dp_*` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
- `mem_rd_data` is combinational and is updated by the write at each edge.

## Test plan
Bench stub datapath for scenarios 1–4: `dp_new_membrane` = `dp_last_membrane`+1, and `dp_is_spike` = (`dp_last_membrane`+1 ≥ `dp_threshold`). NEURONS=4, SYNAPSES=8.

1. **Reset:** pulse `reset` mid-RUN, asynchronously between edges → outputs go immediately to `out_valid`=0, `busy`=0, `in_ready`=1; `mem_rd_data`=0 for all 4 indices.
2. **Sequencing:**
   - Stimulus: write weights 0x01, 0x02, 0x04, 0x08 to slots 0..3, then one step.
   - Response: `dp_weights` reads 0x01, 0x02, 0x04, 0x08 in RUN cycles 1..4; `out_valid` rises 4 cycles after accept; membranes are all 1.
3. **Spiking:**
   - Stimulus: threshold=3, three steps with `out_ready`=1.
   - Response: `out_spikes`=0000, 0000, 1111; membranes are 3.
4. **Backpressure:**
   - Stimulus: hold `out_ready`=0 for 10 cycles after DONE, with `in_valid`=1 throughout.
   - Response: `out_spikes` stays stable; `in_ready`=0 throughout; the next accept happens 1 cycle after `out_ready` rises.
5. **Ignored commands:**
   - Stimulus: `cfg_we` (slot 2, 0xFF) and `clear_state` issued during RUN.
   - Response: both ignored; slot 2 weights and membranes unchanged.
   - Stimulus: in IDLE, `clear_state` together with `in_valid`.
   - Response: membranes are 0; the step is accepted the following cycle.
6. **Real datapath:** replace the stub with a `lif_logic` instance (MEMBRANE_BITS=5) and run random steps → per-neuron membranes and spikes match 4 independent `neuron_lif` references driven with the same inputs.

Source files
------------

// File: rtl/lif_layer_sequencer.sv
// lif_layer_sequencer: shares one combinational LIF datapath across NEURONS neurons.
// Holds per-neuron weights and membranes; takes one input vector and returns one spike vector per step.
module lif_layer_sequencer #(
    parameter int SYNAPSES       = 8,
    parameter int NEURONS        = 4,
    parameter int MEMBRANE_BITS  = $clog2(SYNAPSES) + 2,
    parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_we,
    input  logic [$clog2(NEURONS)-1:0]       cfg_addr,
    input  logic [SYNAPSES-1:0]              cfg_weights,
    input  logic                             clear_state,
    input  logic [2:0]                       shift,
    input  logic [THRESHOLD_BITS-1:0]        threshold,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SYNAPSES-1:0]              in_spikes,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NEURONS-1:0]               out_spikes,
    output logic                             busy,
    output logic [SYNAPSES-1:0]              dp_inputs,
    output logic [SYNAPSES-1:0]              dp_weights,
    output logic signed [MEMBRANE_BITS-1:0]  dp_last_membrane,
    output logic [2:0]                       dp_shift,
    output logic [THRESHOLD_BITS-1:0]        dp_threshold,
    input  logic signed [MEMBRANE_BITS-1:0]  dp_new_membrane,
    input  logic                             dp_is_spike,
    input  logic [$clog2(NEURONS)-1:0]       mem_rd_addr,
    output logic signed [MEMBRANE_BITS-1:0]  mem_rd_data
);
    localparam int IW = $clog2(NEURONS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                           state_q, state_d;
    logic [IW-1:0]                    idx_q, idx_d;
    logic [SYNAPSES-1:0]              in_spikes_q, in_spikes_d;
    logic [2:0]                       shift_q, shift_d;
    logic [THRESHOLD_BITS-1:0]        threshold_q, threshold_d;
    logic [NEURONS-1:0]               spike_acc_q, spike_acc_d;
    logic [SYNAPSES-1:0]              weights_q [NEURONS];
    logic [SYNAPSES-1:0]              weights_d [NEURONS];
    logic signed [MEMBRANE_BITS-1:0]  membrane_q [NEURONS];
    logic signed [MEMBRANE_BITS-1:0]  membrane_d [NEURONS];

    // A pending clear blocks the accept so the clear and a new step never share an edge.
    assign in_ready         = (state_q == IDLE) && !clear_state;
    assign busy             = state_q != IDLE;
    assign out_valid        = state_q == DONE;
    assign out_spikes       = spike_acc_q;
    assign dp_inputs        = in_spikes_q;
    assign dp_weights       = weights_q[idx_q];
    assign dp_last_membrane = membrane_q[idx_q];
    assign dp_shift         = shift_q;
    assign dp_threshold     = threshold_q;
    assign mem_rd_data      = membrane_q[mem_rd_addr];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        in_spikes_d = in_spikes_q;
        shift_d     = shift_q;
        threshold_d = threshold_q;
        spike_acc_d = spike_acc_q;
        weights_d   = weights_q;
        membrane_d  = membrane_q;
        case (state_q)
            IDLE: begin
                if (cfg_we) weights_d[cfg_addr] = cfg_weights;
                if (clear_state) begin
                    membrane_d = '{default: '0};
                end else if (in_valid) begin
                    in_spikes_d = in_spikes;
                    shift_d     = shift;
                    threshold_d = threshold;
                    idx_d       = '0;
                    spike_acc_d = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                membrane_d[idx_q]  = dp_new_membrane;
                spike_acc_d[idx_q] = dp_is_spike;
                idx_d              = idx_q + 1'b1;
                if (idx_q == IW'(NEURONS - 1)) state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            in_spikes_q <= '0;
            shift_q     <= '0;
            threshold_q <= '0;
            spike_acc_q <= '0;
            weights_q   <= '{default: '0};
            membrane_q  <= '{default: '0};
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_spikes_q <= in_spikes_d;
            shift_q     <= shift_d;
            threshold_q <= threshold_d;
            spike_acc_q <= spike_acc_d;
            weights_q   <= weights_d;
            membrane_q  <= membrane_d;
        end
    end
endmodule
